// File: rtl/rx_iq_pkg.sv
// Shared types and constants for the RX I/Q sample buffer.
package rx_iq_pkg;

  // Width of each I or Q word delivered by the DDC.
  localparam int unsigned IQ_W = 24;

  // Default log2 of FIFO depth in sample sets.
  localparam int unsigned DEPTH_LOG2_DEF = 4;

  // One sample set: both receivers, I and Q.
  typedef struct packed {
    logic signed [IQ_W-1:0] rx1_i;
    logic signed [IQ_W-1:0] rx1_q;
    logic signed [IQ_W-1:0] rx2_i;
    logic signed [IQ_W-1:0] rx2_q;
  } iq_set_t;

endpackage

// File: rtl/rx_iq_buffer_if.sv
// DDC-side write bus, bus-interface read handshake, and status outputs of the buffer.
interface rx_iq_buffer_if
  import rx_iq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) ();

  logic signed [IQ_W-1:0] rx1_i_in;
  logic signed [IQ_W-1:0] rx1_q_in;
  logic signed [IQ_W-1:0] rx2_i_in;
  logic signed [IQ_W-1:0] rx2_q_in;
  logic                   rx_iq_valid;
  logic                   IQ_RX_READ_REQ;
  logic                   IQ_RX_READ_CLK;
  logic                   flush;
  logic                   overrun_clear;
  logic signed [IQ_W-1:0] RX1_I;
  logic signed [IQ_W-1:0] RX1_Q;
  logic signed [IQ_W-1:0] RX2_I;
  logic signed [IQ_W-1:0] RX2_Q;
  logic                   in_empty;
  logic [DEPTH_LOG2:0]    fill_level;
  logic                   iq_overrun;

  // Producer / controller side.
  modport master (
    output rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in, rx_iq_valid,
    output IQ_RX_READ_REQ, IQ_RX_READ_CLK, flush, overrun_clear,
    input  RX1_I, RX1_Q, RX2_I, RX2_Q, in_empty, fill_level, iq_overrun
  );

  // Buffer side.
  modport slave (
    input  rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in, rx_iq_valid,
    input  IQ_RX_READ_REQ, IQ_RX_READ_CLK, flush, overrun_clear,
    output RX1_I, RX1_Q, RX2_I, RX2_Q, in_empty, fill_level, iq_overrun
  );

endinterface

// File: rtl/iq_fifo_mem.sv
// Register-array storage for the sample-set FIFO: one write port, one combinational read port.
module iq_fifo_mem
  import rx_iq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  iq_set_t               wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output iq_set_t               rdata_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  iq_set_t mem_q [Depth];

  // Storage is deliberately not reset; validity is tracked by the pointer logic.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_iq_buffer.sv
// FIFO of RX1/RX2 I/Q sample sets between the DDC and the MCU parallel-bus interface.
// Head entry is first-word-fall-through; a qualified rising edge of READ_CLK pops it.
module rx_iq_buffer
  import rx_iq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic          clk_in,
  input  logic          reset_in,
  rx_iq_buffer_if.slave bus
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic                  read_clk_q;

  logic    empty, full, pop_req, do_pop, do_wr, ovr_set;
  iq_set_t wdata, rdata, head;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LevelFull);
  assign pop_req = bus.IQ_RX_READ_REQ & bus.IQ_RX_READ_CLK & ~read_clk_q;
  // Flush beats everything; a pop on an empty FIFO is dropped (no write bypass).
  assign do_pop  = pop_req & ~empty & ~bus.flush;
  // A full FIFO still accepts a write when the same edge frees a slot.
  assign do_wr   = bus.rx_iq_valid & (~full | do_pop) & ~bus.flush;
  assign ovr_set = bus.rx_iq_valid & full & ~do_pop & ~bus.flush;

  // Assemble the incoming sample set.
  always_comb begin
    wdata.rx1_i = bus.rx1_i_in;
    wdata.rx1_q = bus.rx1_q_in;
    wdata.rx2_i = bus.rx2_i_in;
    wdata.rx2_q = bus.rx2_q_in;
  end

  iq_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk_i  (clk_in),
    .we_i   (do_wr),
    .waddr_i(wr_ptr_q),
    .wdata_i(wdata),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  // Next-state for pointers, level and the sticky overrun flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_wr, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    // A new overrun in the same cycle as a clear keeps the flag set.
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clear) begin
      overrun_d = 1'b0;
    end
  end

  // State registers, including the READ_CLK edge detector.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      read_clk_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      read_clk_q <= bus.IQ_RX_READ_CLK;
    end
  end

  // Head entry falls through; forced to zero while empty.
  always_comb begin
    head = empty ? '0 : rdata;
  end

  assign bus.RX1_I      = head.rx1_i;
  assign bus.RX1_Q      = head.rx1_q;
  assign bus.RX2_I      = head.rx2_i;
  assign bus.RX2_Q      = head.rx2_q;
  assign bus.in_empty   = empty;
  assign bus.fill_level = level_q;
  assign bus.iq_overrun = overrun_q;

endmodule

// File: tb/tb_rx_iq_buffer.sv
// Directed self-checking bench for rx_iq_buffer.
module tb_rx_iq_buffer;
  import rx_iq_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rx_iq_buffer_if #(.DEPTH_LOG2(4)) iq_bus ();

  rx_iq_buffer #(
    .DEPTH_LOG2(4)
  ) dut (
    .clk_in  (clk),
    .reset_in(rst),
    .bus     (iq_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected sample set for index k.
  function automatic iq_set_t mk(input int k);
    iq_set_t s;
    s.rx1_i = 24'(32'h100 + k * 3);
    s.rx1_q = 24'(32'hA00000 + k);
    s.rx2_i = 24'(32'h050000 + k * 7);
    s.rx2_q = 24'(~k);
    return s;
  endfunction

  function automatic logic [95:0] head();
    return {iq_bus.RX1_I, iq_bus.RX1_Q, iq_bus.RX2_I, iq_bus.RX2_Q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input iq_set_t s);
    iq_bus.rx1_i_in = s.rx1_i;
    iq_bus.rx1_q_in = s.rx1_q;
    iq_bus.rx2_i_in = s.rx2_i;
    iq_bus.rx2_q_in = s.rx2_q;
  endtask

  task automatic write(input iq_set_t s);
    set_data(s);
    iq_bus.rx_iq_valid = 1'b1;
    tick();
    iq_bus.rx_iq_valid = 1'b0;
  endtask

  // Pop with a clean READ_CLK pulse; the head is checked as sampled on the popping edge.
  task automatic pop_check(input string tag, input logic [95:0] exp);
    iq_bus.IQ_RX_READ_REQ = 1'b1;
    iq_bus.IQ_RX_READ_CLK = 1'b1;
    check_eq(tag, head(), exp);
    tick();
    iq_bus.IQ_RX_READ_CLK = 1'b0;
    iq_bus.IQ_RX_READ_REQ = 1'b0;
    tick();
  endtask

  task automatic pop_blind();
    iq_bus.IQ_RX_READ_REQ = 1'b1;
    iq_bus.IQ_RX_READ_CLK = 1'b1;
    tick();
    iq_bus.IQ_RX_READ_CLK = 1'b0;
    iq_bus.IQ_RX_READ_REQ = 1'b0;
    tick();
  endtask

  initial begin
    iq_setup: begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      set_data('0);
      iq_bus.rx_iq_valid    = 1'b0;
      iq_bus.IQ_RX_READ_REQ = 1'b0;
      iq_bus.IQ_RX_READ_CLK = 1'b0;
      iq_bus.flush          = 1'b0;
      iq_bus.overrun_clear  = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_empty", iq_bus.in_empty, 1);
    check_eq("rst_level", iq_bus.fill_level, 0);
    check_eq("rst_head", head(), 0);
    check_eq("rst_ovr", iq_bus.iq_overrun, 0);

    // Single write then pop.
    write('{rx1_i: 24'h123456, rx1_q: 24'hFEDCBA, rx2_i: 24'h000001, rx2_q: 24'h000001});
    check_eq("w1_rx1_i", iq_bus.RX1_I, 24'h123456);
    check_eq("w1_head", head(), {24'h123456, 24'hFEDCBA, 24'h000001, 24'h000001});
    check_eq("w1_empty", iq_bus.in_empty, 0);
    iq_bus.IQ_RX_READ_REQ = 1'b1;
    iq_bus.IQ_RX_READ_CLK = 1'b1;
    check_eq("p1_sample", iq_bus.RX1_I, 24'h123456);
    tick();
    check_eq("p1_empty", iq_bus.in_empty, 1);
    check_eq("p1_head0", head(), 0);
    iq_bus.IQ_RX_READ_CLK = 1'b0;
    iq_bus.IQ_RX_READ_REQ = 1'b0;
    tick();

    // Fill to 16, 17th write overruns and is lost.
    for (int k = 1; k <= 17; k++) write(mk(k));
    check_eq("full_level", iq_bus.fill_level, 16);
    check_eq("full_ovr", iq_bus.iq_overrun, 1);
    for (int k = 1; k <= 16; k++) pop_check($sformatf("drain_%0d", k), mk(k));
    check_eq("drain_empty", iq_bus.in_empty, 1);
    check_eq("drain_level", iq_bus.fill_level, 0);

    // Clear overrun, refill, then simultaneous write+pop while full.
    iq_bus.overrun_clear = 1'b1;
    tick();
    iq_bus.overrun_clear = 1'b0;
    check_eq("clr_ovr", iq_bus.iq_overrun, 0);
    for (int k = 20; k <= 35; k++) write(mk(k));
    set_data(mk(50));
    iq_bus.rx_iq_valid    = 1'b1;
    iq_bus.IQ_RX_READ_REQ = 1'b1;
    iq_bus.IQ_RX_READ_CLK = 1'b1;
    check_eq("wp_head", head(), mk(20));
    tick();
    iq_bus.rx_iq_valid    = 1'b0;
    iq_bus.IQ_RX_READ_CLK = 1'b0;
    iq_bus.IQ_RX_READ_REQ = 1'b0;
    check_eq("wp_level", iq_bus.fill_level, 16);
    check_eq("wp_ovr", iq_bus.iq_overrun, 0);
    tick();
    for (int k = 21; k <= 35; k++) pop_check($sformatf("wp_drain_%0d", k), mk(k));
    pop_check("wp_last", mk(50));
    check_eq("wp_empty", iq_bus.in_empty, 1);

    // READ_CLK held high pops once; READ_CLK without READ_REQ is ignored.
    write(mk(60));
    write(mk(61));
    iq_bus.IQ_RX_READ_REQ = 1'b1;
    iq_bus.IQ_RX_READ_CLK = 1'b1;
    repeat (5) tick();
    iq_bus.IQ_RX_READ_CLK = 1'b0;
    iq_bus.IQ_RX_READ_REQ = 1'b0;
    tick();
    check_eq("hold_level", iq_bus.fill_level, 1);
    check_eq("hold_head", head(), mk(61));
    iq_bus.IQ_RX_READ_CLK = 1'b1;
    tick();
    iq_bus.IQ_RX_READ_CLK = 1'b0;
    tick();
    check_eq("noreq_level", iq_bus.fill_level, 1);
    pop_check("hold_pop", mk(61));
    pop_blind();
    check_eq("uflow_level", iq_bus.fill_level, 0);
    check_eq("uflow_empty", iq_bus.in_empty, 1);
    write(mk(62));
    check_eq("uflow_ptr", head(), mk(62));
    pop_check("uflow_pop", mk(62));

    // Set overrun, bring level to 7, then flush with a simultaneous write.
    for (int k = 70; k <= 86; k++) write(mk(k));
    for (int k = 70; k <= 78; k++) pop_check($sformatf("pre_fl_%0d", k), mk(k));
    check_eq("pre_fl_level", iq_bus.fill_level, 7);
    set_data(mk(90));
    iq_bus.rx_iq_valid = 1'b1;
    iq_bus.flush       = 1'b1;
    tick();
    iq_bus.rx_iq_valid = 1'b0;
    iq_bus.flush       = 1'b0;
    check_eq("fl_level", iq_bus.fill_level, 0);
    check_eq("fl_empty", iq_bus.in_empty, 1);
    check_eq("fl_head", head(), 0);
    check_eq("fl_ovr", iq_bus.iq_overrun, 1);
    iq_bus.overrun_clear = 1'b1;
    tick();
    iq_bus.overrun_clear = 1'b0;
    check_eq("fl_clr_ovr", iq_bus.iq_overrun, 0);
    write(mk(91));
    check_eq("fl_ptr", head(), mk(91));

    // Asynchronous reset mid-stream with overrun set.
    for (int k = 100; k <= 116; k++) write(mk(k));
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_empty", iq_bus.in_empty, 1);
    check_eq("arst_level", iq_bus.fill_level, 0);
    check_eq("arst_head", head(), 0);
    check_eq("arst_ovr", iq_bus.iq_overrun, 0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_empty", iq_bus.in_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
